rx_fifo: RTL and testbench

RX_FIFO -- requirements
Module: rx_fifo

---
 rtl/rx_fifo_pkg.sv | 15 +
 rtl/rx_fifo_mem.sv | 37 +++
 rtl/rx_fifo.sv | 105 ++++++++++
 tb/tb_rx_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_fifo_pkg.sv
// Shared defaults and sizing helper for the receive FIFO.
// Optional sticky error flags are enabled with the RX_FIFO_ERR_EN macro.
package rx_fifo_pkg;

    localparam int unsigned RX_WIDTH  = 32;
    localparam int unsigned RX_DEPTH  = 8;
    localparam int unsigned RX_AF_LVL = 6;
    localparam int unsigned RX_AE_LVL = 2;

    // Pointer width for a power-of-two depth; count is one bit wider.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x WIDTH storage for the receive FIFO: synchronous write, registered read.
// The read register is reset so the FIFO output is clean after reset.
module rx_fifo_mem
    import rx_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = RX_WIDTH,
    parameter int unsigned DEPTH = RX_DEPTH,
    localparam int unsigned AW   = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; stale words are unreachable via the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_fifo.sv
// Receive FIFO behind the lane-merge stage: pointers, occupancy count, flags.
// Define RX_FIFO_ERR_EN to add sticky overflow_err/underflow_err outputs.
module rx_fifo
    import rx_fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = RX_WIDTH,
    parameter int unsigned DEPTH  = RX_DEPTH,
    parameter int unsigned AF_LVL = RX_AF_LVL,
    parameter int unsigned AE_LVL = RX_AE_LVL
) (
    input  logic                     clk_2f,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     valid_in,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ptr_width(DEPTH):0] count
`ifdef RX_FIFO_ERR_EN
    ,
    output logic                     overflow_err,
    output logic                     underflow_err
`endif
);

    localparam int unsigned AW = ptr_width(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full FIFO is allowed only when a pop frees a slot this cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = valid_in && (!full || pop_ok);

    rx_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk_2f),
        .rst_n   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            valid_out <= pop_ok;
        end
    end

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LVL));
    assign almost_empty = (count <= CW'(AE_LVL));

`ifdef RX_FIFO_ERR_EN
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (valid_in && full && !pop_ok) begin
                overflow_err <= 1'b1;
            end
            if (pop && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Directed self-checking bench for rx_fifo with default parameters.
module tb_rx_fifo;

    logic        clk_2f;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        pop;
    logic [31:0] data_out;
    logic        valid_out;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
`ifdef RX_FIFO_ERR_EN
    logic        overflow_err;
    logic        underflow_err;
`endif

    int unsigned n_vec;
    int unsigned n_err;

    rx_fifo dut (
        .clk_2f       (clk_2f),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef RX_FIFO_ERR_EN
        ,
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
`endif
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic chk_flags(input string tag, input int unsigned c);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".full"}, 32'(full), 32'(c == 8));
        chk({tag, ".empty"}, 32'(empty), 32'(c == 0));
        chk({tag, ".af"}, 32'(almost_full), 32'(c >= 6));
        chk({tag, ".ae"}, 32'(almost_empty), 32'(c <= 2));
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        data_in  = '0;
        valid_in = 1'b0;
        pop      = 1'b0;

        // Reset state
        #3;
        chk_flags("rst", 0);
        chk("rst.valid_out", 32'(valid_out), 32'd0);
        chk("rst.data_out", data_out, 32'h0);
        #8 reset = 1'b1;
        step();

        // Basic in-order push then pop
        valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 32'hA000_0000 + 32'(i);
            step();
        end
        valid_in = 1'b0;
        chk_flags("basic.filled", 4);
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("basic.valid_out", 32'(valid_out), 32'd1);
            chk("basic.data_out", data_out, 32'hA000_0000 + 32'(i));
        end
        pop = 1'b0;
        step();
        chk("basic.valid_drop", 32'(valid_out), 32'd0);
        chk("basic.data_hold", data_out, 32'hA000_0003);
        chk_flags("basic.end", 0);

        // Fill, overflow drop, drain
        valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 32'hB000_0000 + 32'(i);
            step();
        end
        chk_flags("ovf.full", 8);
        data_in = 32'hDEAD_BEEF;
        step();
        valid_in = 1'b0;
        chk_flags("ovf.drop", 8);
`ifdef RX_FIFO_ERR_EN
        chk("ovf.overflow_err", 32'(overflow_err), 32'd1);
        chk("ovf.underflow_err", 32'(underflow_err), 32'd0);
`endif
        pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ovf.data_out", data_out, 32'hB000_0000 + 32'(i));
        end
        pop = 1'b0;
        step();
        chk_flags("ovf.drained", 0);

        // Full FIFO with simultaneous push and pop
        valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 32'hC000_0000 + 32'(i);
            step();
        end
        data_in = 32'hC000_0008;
        pop     = 1'b1;
        step();
        valid_in = 1'b0;
        chk("both.valid_out", 32'(valid_out), 32'd1);
        chk("both.data_out", data_out, 32'hC000_0000);
        chk_flags("both", 8);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("both.drain", data_out, 32'hC000_0000 + 32'(i));
        end
        pop = 1'b0;
        step();
        chk_flags("both.end", 0);

        // Empty FIFO: push with pop, no fall-through
        data_in  = 32'h1234_5678;
        valid_in = 1'b1;
        pop      = 1'b1;
        step();
        valid_in = 1'b0;
        chk("nft.valid_out", 32'(valid_out), 32'd0);
        chk("nft.data_hold", data_out, 32'hC000_0008);
        chk_flags("nft", 1);
        step();
        chk("nft.valid_out2", 32'(valid_out), 32'd1);
        chk("nft.data_out", data_out, 32'h1234_5678);
        pop = 1'b0;
        step();
        chk_flags("nft.end", 0);
`ifdef RX_FIFO_ERR_EN
        chk("nft.underflow_err", 32'(underflow_err), 32'd1);
`endif

        // Occupancy sweep 0..8..0 with flag decode at every level
        valid_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_in = 32'hE000_0000 + 32'(i);
            step();
            chk_flags("sweep.up", i);
        end
        valid_in = 1'b0;
        pop      = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            step();
            chk("sweep.data", data_out, 32'hE000_0000 + 32'(8 - i));
            chk_flags("sweep.down", i);
        end
        pop = 1'b0;

        // Streaming push/pop across pointer wrap
        valid_in = 1'b1;
        data_in  = 32'hD000_0000;
        step();
        pop = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            data_in = 32'hD000_0000 + 32'(i);
            step();
            chk("wrap.data", data_out, 32'hD000_0000 + 32'(i - 1));
            chk("wrap.count", 32'(count), 32'd1);
        end
        valid_in = 1'b0;
        step();
        chk("wrap.last", data_out, 32'hD000_0014);
        pop = 1'b0;

        // Asynchronous reset mid-operation with count=5 and a read in flight
        valid_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 32'hF000_0000 + 32'(i);
            step();
        end
        valid_in = 1'b0;
        pop      = 1'b1;
        step();
        pop = 1'b0;
        chk("arst.pre_valid", 32'(valid_out), 32'd1);
        chk("arst.pre_data", data_out, 32'hF000_0000);
        chk_flags("arst.pre", 5);
        #1 reset = 1'b0;
        #1;
        chk_flags("arst", 0);
        chk("arst.valid_out", 32'(valid_out), 32'd0);
        chk("arst.data_out", data_out, 32'h0);
`ifdef RX_FIFO_ERR_EN
        chk("arst.overflow_err", 32'(overflow_err), 32'd0);
        chk("arst.underflow_err", 32'(underflow_err), 32'd0);
`endif
        #3 reset = 1'b1;
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("arst.post_valid", 32'(valid_out), 32'd0);
        chk_flags("arst.post", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
